// File: rtl/ram_cell_sequencer_pkg.sv
// Shared definitions for the RAM cell sequencer: command opcodes and FSM state encodings.
// Also used by the core, which drives the command interface with the same opcodes.
package ram_cell_sequencer_pkg;

    localparam int OP_WIDTH = 2;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_LOAD  = 2'd0,
        OP_STORE = 2'd1,
        OP_INC   = 2'd2,
        OP_DEC   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_ISSUE = 2'd1,
        ST_RD_CAPT  = 2'd2,
        ST_WR       = 2'd3
    } state_e;

endpackage

// File: rtl/ram_cell_sequencer_cell_step.sv
// Combinational cell increment/decrement with wrap inside 0..CellMax.
// Out-of-range inputs are first clamped to CellMax; shared with the core's accumulator.
module cell_step #(
    parameter int DataSize = 10,
    parameter int CellMax  = 255
) (
    input  logic [DataSize-1:0] value_i,
    input  logic                dec_i,
    output logic [DataSize-1:0] value_o
);

    localparam logic [DataSize-1:0] MAX_V  = DataSize'(CellMax);
    localparam logic [DataSize-1:0] ONE_V  = DataSize'(1);
    localparam logic [DataSize-1:0] ZERO_V = '0;

    logic [DataSize-1:0] clamped;

    assign clamped = (value_i > MAX_V) ? MAX_V : value_i;

    always_comb begin
        if (dec_i) begin
            value_o = (clamped == ZERO_V) ? MAX_V : clamped - ONE_V;
        end else begin
            value_o = (clamped == MAX_V) ? ZERO_V : clamped + ONE_V;
        end
    end

endmodule

// File: rtl/ram_cell_sequencer.sv
// Initiator side of the synchronous data RAM: runs LOAD/STORE/INC/DEC cell commands
// from the core, with INC/DEC done as read-modify-write, and reports the resulting value.
module ram_cell_sequencer
    import ram_cell_sequencer_pkg::*;
#(
    parameter int AddressSize = 16,
    parameter int DataSize    = 10,
    parameter int CellMax     = 255
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Req,
    output logic                   Ready,
    input  logic [OP_WIDTH-1:0]    Op,
    input  logic [AddressSize-1:0] Addr,
    input  logic [DataSize-1:0]    WrData,
    output logic                   Done,
    output logic [DataSize-1:0]    DataOut,
    output logic                   Zero,
    output logic [AddressSize-1:0] RamAddress,
    output logic [DataSize-1:0]    RamIn,
    input  logic [DataSize-1:0]    RamOut,
    output logic                   RamCS,
    output logic                   RamWE_n
);

    state_e                 state_q,    state_d;
    op_e                    op_q,       op_d;
    logic [AddressSize-1:0] ram_addr_q, ram_addr_d;
    logic [DataSize-1:0]    ram_in_q,   ram_in_d;
    logic                   ram_cs_q,   ram_cs_d;
    logic                   ram_we_n_q, ram_we_n_d;
    logic                   done_q,     done_d;
    logic [DataSize-1:0]    data_out_q, data_out_d;
    logic [DataSize-1:0]    stepped;
    logic                   accept;

    cell_step #(
        .DataSize (DataSize),
        .CellMax  (CellMax)
    ) u_cell_step (
        .value_i (RamOut),
        .dec_i   (op_q == OP_DEC),
        .value_o (stepped)
    );

    assign Ready  = (state_q == ST_IDLE);
    assign accept = Req && Ready;

    // NOTE: every *_d gets its hold value first so no path through the case can infer a latch.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        ram_addr_d = ram_addr_q;
        ram_in_d   = ram_in_q;
        ram_cs_d   = ram_cs_q;
        ram_we_n_d = 1'b1;
        done_d     = 1'b0;
        data_out_d = data_out_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d       = op_e'(Op);
                    ram_addr_d = Addr;
                    ram_cs_d   = 1'b1;
                    if (op_e'(Op) == OP_STORE) begin
                        ram_in_d   = WrData;
                        ram_we_n_d = 1'b0;
                        state_d    = ST_WR;
                    end else begin
                        state_d    = ST_RD_ISSUE;
                    end
                end
            end

            ST_RD_ISSUE: begin
                state_d = ST_RD_CAPT;
            end

            // RamCS is still high here, so RamOut is driven by the RAM when sampled.
            ST_RD_CAPT: begin
                if (op_q == OP_LOAD) begin
                    data_out_d = RamOut;
                    done_d     = 1'b1;
                    ram_cs_d   = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    ram_in_d   = stepped;
                    data_out_d = stepped;
                    ram_we_n_d = 1'b0;
                    state_d    = ST_WR;
                end
            end

            ST_WR: begin
                data_out_d = ram_in_q;
                done_d     = 1'b1;
                ram_cs_d   = 1'b0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_LOAD;
            ram_addr_q <= '0;
            ram_in_q   <= '0;
            ram_cs_q   <= 1'b0;
            ram_we_n_q <= 1'b1;
            done_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            ram_addr_q <= ram_addr_d;
            ram_in_q   <= ram_in_d;
            ram_cs_q   <= ram_cs_d;
            ram_we_n_q <= ram_we_n_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
        end
    end

    assign Done       = done_q;
    assign DataOut    = data_out_q;
    assign Zero       = (data_out_q == '0);
    assign RamAddress = ram_addr_q;
    assign RamIn      = ram_in_q;
    assign RamCS      = ram_cs_q;
    assign RamWE_n    = ram_we_n_q;

endmodule

// File: tb/tb_ram_cell_sequencer.sv
// Self-checking bench: sequencer paired with a synchronous RAM model, checked by a scoreboard
// of expected result values and Done cycles.
module tb_ram_cell_sequencer;

    localparam int AW = 16;
    localparam int DW = 10;
    localparam int CMAX = 255;

    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] STORE = 2'd1;
    localparam logic [1:0] INC   = 2'd2;
    localparam logic [1:0] DEC   = 2'd3;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          Req = 1'b0;
    logic          Ready;
    logic [1:0]    Op = 2'd0;
    logic [AW-1:0] Addr = '0;
    logic [DW-1:0] WrData = '0;
    logic          Done;
    logic [DW-1:0] DataOut;
    logic          Zero;
    logic [AW-1:0] RamAddress;
    logic [DW-1:0] RamIn;
    logic [DW-1:0] RamOut;
    logic          RamCS;
    logic          RamWE_n;

    ram_cell_sequencer #(
        .AddressSize (AW),
        .DataSize    (DW),
        .CellMax     (CMAX)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Req        (Req),
        .Ready      (Ready),
        .Op         (Op),
        .Addr       (Addr),
        .WrData     (WrData),
        .Done       (Done),
        .DataOut    (DataOut),
        .Zero       (Zero),
        .RamAddress (RamAddress),
        .RamIn      (RamIn),
        .RamOut     (RamOut),
        .RamCS      (RamCS),
        .RamWE_n    (RamWE_n)
    );

    always #5 Clk = ~Clk;

    // Synchronous RAM model: registered read, write on the edge when CS=1 and WE_n=0.
    logic [DW-1:0] ram_mem [0:65535];
    logic [DW-1:0] ram_q;
    logic          ram_rst_n;
    assign ram_rst_n = ~Rst;

    always @(posedge Clk or negedge ram_rst_n) begin
        if (!ram_rst_n) begin
            ram_q <= '0;
        end else if (RamCS) begin
            if (!RamWE_n) ram_mem[RamAddress] <= RamIn;
            else          ram_q <= ram_mem[RamAddress];
        end
    end
    assign RamOut = RamCS ? ram_q : 'z;

    typedef struct {
        logic [DW-1:0] val;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mem_m [0:65535];
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;
    int            stray = 0;
    int            we_cnt = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] step_m(input logic [DW-1:0] x, input bit dec);
        int s;
        s = (int'(x) > CMAX) ? CMAX : int'(x);
        if (dec) return (s == 0) ? DW'(CMAX) : DW'(s - 1);
        return (s == CMAX) ? DW'(0) : DW'(s + 1);
    endfunction

    // Completion monitor: pops one expected result per Done pulse.
    always @(negedge Clk) begin
        if (!Rst && Done) begin
            if (sb.size() == 0) begin
                stray++;
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("data", 32'(DataOut), 32'(e.val));
                check("zero", 32'(Zero), 32'(e.val == '0));
                check("done_cycle", cyc, e.cyc);
            end
        end
        if (!Rst && !RamWE_n) we_cnt++;
    end

    task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input bit hold, input bit expect_b2b);
        int n;
        int lat;
        logic [DW-1:0] v;
        @(negedge Clk);
        Req = 1'b1; Op = op; Addr = a; WrData = wd;
        n = 0;
        while (!Ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        check("accept", 32'(Ready), 32'd1);
        if (expect_b2b) check("b2b_on_done", 32'(Done), 32'd1);
        case (op)
            LOAD:    begin v = mem_m[a];          lat = 2; end
            STORE:   begin v = wd;                lat = 1; end
            INC:     begin v = step_m(mem_m[a], 1'b0); lat = 3; end
            default: begin v = step_m(mem_m[a], 1'b1); lat = 3; end
        endcase
        if (op != LOAD) mem_m[a] = v;
        sb.push_back('{val: v, cyc: cyc + lat + 1});
        @(posedge Clk);
        #1;
        if (!hold) Req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        check("drain", sb.size(), 0);
        repeat (2) @(negedge Clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we_n"},  32'(RamWE_n), 32'd1);
        check({tag, "_ready"}, 32'(Ready), 32'd1);
        check({tag, "_zero"},  32'(Zero), 32'd1);
        check({tag, "_dout"},  32'(DataOut), 32'd0);
        check({tag, "_done"},  32'(Done), 32'd0);
        check({tag, "_cs"},    32'(RamCS), 32'd0);
        check({tag, "_addr"},  32'(RamAddress), 32'd0);
        check({tag, "_ramin"}, 32'(RamIn), 32'd0);
    endtask

    initial begin
        int we_base;

        // Power-on reset.
        repeat (3) @(negedge Clk);
        check_reset_outputs("por");
        Rst = 1'b0;

        // Reset mid-operation while a STORE sits in WR.
        @(negedge Clk);
        Req = 1'b1; Op = STORE; Addr = 16'h0100; WrData = 10'd7;
        @(posedge Clk);
        #1;
        Req = 1'b0;
        check("wr_state_we_n", 32'(RamWE_n), 32'd0);
        #2;
        Rst = 1'b1;
        #1;
        check_reset_outputs("midop");
        @(negedge Clk);
        Rst = 1'b0;

        // STORE then LOAD.
        send(STORE, 16'h0010, 10'd42, 1'b0, 1'b0);
        send(LOAD,  16'h0010, 10'd0,  1'b0, 1'b0);
        drain();

        // INC wraps CellMax to zero.
        send(STORE, 16'h0020, 10'd255, 1'b0, 1'b0);
        send(INC,   16'h0020, 10'd0,   1'b0, 1'b0);
        send(LOAD,  16'h0020, 10'd0,   1'b0, 1'b0);
        drain();

        // DEC wraps zero to CellMax; INC at the top address.
        send(STORE, 16'h0030, 10'd0,  1'b0, 1'b0);
        send(DEC,   16'h0030, 10'd0,  1'b0, 1'b0);
        send(LOAD,  16'h0030, 10'd0,  1'b0, 1'b0);
        send(STORE, 16'hFFFF, 10'd17, 1'b0, 1'b0);
        send(INC,   16'hFFFF, 10'd0,  1'b0, 1'b0);
        send(LOAD,  16'hFFFF, 10'd0,  1'b0, 1'b0);
        send(DEC,   16'h0031, 10'd0,  1'b0, 1'b0);
        drain();

        // Back-to-back with Req held high: exactly one write cycle overall.
        send(STORE, 16'h0055, 10'd100, 1'b0, 1'b0);
        drain();
        we_base = we_cnt;
        send(LOAD, 16'h0055, 10'd0, 1'b1, 1'b0);
        send(INC,  16'h0055, 10'd0, 1'b1, 1'b1);
        send(LOAD, 16'h0055, 10'd0, 1'b0, 1'b1);
        drain();
        check("b2b_we_cycles", we_cnt - we_base, 1);
        check("b2b_final", 32'(DataOut), 32'd101);

        // Out-of-range value clamps before stepping; stray Req while busy is ignored.
        send(STORE, 16'h0040, 10'd900, 1'b0, 1'b0);
        send(INC,   16'h0040, 10'd0,   1'b0, 1'b0);
        send(LOAD,  16'h0040, 10'd0,   1'b0, 1'b0);
        Req = 1'b1; Op = STORE; Addr = 16'h0040; WrData = 10'd5;
        @(posedge Clk);
        #1;
        Req = 1'b0;
        drain();
        send(LOAD, 16'h0040, 10'd0, 1'b0, 1'b0);
        drain();
        repeat (4) @(negedge Clk);
        check("stray_done", stray, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
